// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared scoreboard slot type and forwarding-select constants
package hazard_pkg;

    localparam int MAX_DEPTH    = 8;
    localparam int MAX_REG_BITS = 8;

    // Select field is sized for the largest supported DEPTH; SEL_RF is never a slot index
    localparam int SEL_W = $clog2(MAX_DEPTH + 1);
    localparam logic [SEL_W-1:0] SEL_RF = SEL_W'(MAX_DEPTH);

    typedef struct packed {
        logic                    valid;
        logic [MAX_REG_BITS-1:0] wr_reg;
        logic                    is_load;
    } slot_t;

endpackage

// File: rtl/fwd_operand_select.sv
// rtl/fwd_operand_select.sv - youngest-slot priority match and data mux for one source operand
module fwd_operand_select
    import hazard_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_BITS = 5,
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 1
) (
    input  logic                      use_reg,
    input  logic [REG_BITS-1:0]       src_reg,
    input  slot_t [DEPTH-1:0]         slots,
    input  logic [DEPTH*DATA_W-1:0]   stage_data,
    input  logic [DATA_W-1:0]         rf_data,
    output logic                      hit,
    output logic                      ready,
    output logic [DATA_W-1:0]         data
);

    logic [SEL_W-1:0]        sel;
    logic [MAX_REG_BITS-1:0] src_ext;

    assign src_ext = MAX_REG_BITS'(src_reg);

    // Scan oldest to youngest so the smallest matching index is the one left standing
    always_comb begin
        hit   = 1'b0;
        ready = 1'b0;
        sel   = SEL_RF;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (use_reg && slots[k].valid && (slots[k].wr_reg != '0) &&
                (slots[k].wr_reg == src_ext)) begin
                hit   = 1'b1;
                ready = !(slots[k].is_load && (k < LOAD_LAT));
                sel   = SEL_W'(k);
            end
        end
    end

    always_comb begin
        data = rf_data;
        for (int k = 0; k < DEPTH; k++) begin
            if (sel == SEL_W'(k)) begin
                data = stage_data[k*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - in-flight destination scoreboard, operand forwarding and load-use stall
module pipe_hazard_unit
    import hazard_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_BITS = 5,
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    issue_valid,
    input  logic [REG_BITS-1:0]     issue_rs,
    input  logic [REG_BITS-1:0]     issue_rt,
    input  logic                    issue_use_rs,
    input  logic                    issue_use_rt,
    input  logic                    issue_wr_en,
    input  logic [REG_BITS-1:0]     issue_wr_reg,
    input  logic                    issue_is_load,
    input  logic                    flush,
    input  logic [DATA_W-1:0]       rf_rd1,
    input  logic [DATA_W-1:0]       rf_rd2,
    input  logic [DEPTH*DATA_W-1:0] stage_data,
    output logic [DATA_W-1:0]       opA,
    output logic [DATA_W-1:0]       opB,
    output logic                    stall,
    output logic [CNT_W-1:0]        stall_cycles
);

    slot_t [DEPTH-1:0] slots;
    slot_t             new_slot;
    logic              rs_hit, rs_ready, rt_hit, rt_ready;
    logic              issue_go;

    fwd_operand_select #(
        .DATA_W(DATA_W), .REG_BITS(REG_BITS), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT)
    ) u_fwd_rs (
        .use_reg(issue_use_rs), .src_reg(issue_rs), .slots(slots),
        .stage_data(stage_data), .rf_data(rf_rd1),
        .hit(rs_hit), .ready(rs_ready), .data(opA)
    );

    fwd_operand_select #(
        .DATA_W(DATA_W), .REG_BITS(REG_BITS), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT)
    ) u_fwd_rt (
        .use_reg(issue_use_rt), .src_reg(issue_rt), .slots(slots),
        .stage_data(stage_data), .rf_data(rf_rd2),
        .hit(rt_hit), .ready(rt_ready), .data(opB)
    );

    assign stall    = issue_valid & ~flush & ((rs_hit & ~rs_ready) | (rt_hit & ~rt_ready));
    assign issue_go = issue_valid & ~stall & ~flush;

    // Non-writing instructions enter with wr_reg=0 so they can never be live
    always_comb begin
        new_slot         = '0;
        new_slot.valid   = issue_go;
        new_slot.wr_reg  = issue_wr_en ? MAX_REG_BITS'(issue_wr_reg) : '0;
        new_slot.is_load = issue_go & issue_is_load;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            slots        <= '0;
            stall_cycles <= '0;
        end else begin
            slots[0] <= issue_go ? new_slot : '0;
            for (int k = 1; k < DEPTH; k++) begin
                slots[k] <= slots[k-1];
            end
            if (stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
        end
    end

endmodule
